// File: rtl/lcd1602_bus_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd1602_bus_driver: HD44780 8-bit bus timing stage (valid/ready in)      |
// | Optional LCD_BUSY_POLL_EN: busy-flag polling replaces fixed EXEC wait.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd1602_bus_driver #(
  parameter int T_POWERUP_CYC   = 2000000,
  parameter int T_SETUP_CYC     = 4,
  parameter int T_PULSE_CYC     = 25,
  parameter int T_HOLD_CYC      = 4,
  parameter int T_EXEC_CYC      = 2000,
  parameter int T_EXEC_LONG_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
`ifdef LCD_BUSY_POLL_EN
  input  logic [7:0] lcd_data_in,
`endif
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy
);

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int C_PWR  = f_max(T_POWERUP_CYC, 1);
  localparam int C_SET  = f_max(T_SETUP_CYC, 1);
  localparam int C_PUL  = f_max(T_PULSE_CYC, 1);
  localparam int C_HLD  = f_max(T_HOLD_CYC, 1);
  localparam int C_EXE  = f_max(T_EXEC_CYC, 1);
  localparam int C_LONG = f_max(T_EXEC_LONG_CYC, 1);
  localparam int C_MAX  = f_max(f_max(f_max(C_PWR, C_SET), f_max(C_PUL, C_HLD)), f_max(C_EXE, C_LONG));
  localparam int CW     = $clog2(C_MAX) + 1;

  localparam logic [3:0] S_POWERUP = 4'd0;
  localparam logic [3:0] S_IDLE    = 4'd1;
  localparam logic [3:0] S_SETUP   = 4'd2;
  localparam logic [3:0] S_PULSE   = 4'd3;
  localparam logic [3:0] S_HOLD    = 4'd4;
  localparam logic [3:0] S_EXEC    = 4'd5;
`ifdef LCD_BUSY_POLL_EN
  localparam logic [3:0] S_PSETUP  = 4'd6;
  localparam logic [3:0] S_PPULSE  = 4'd7;
  localparam logic [3:0] S_PHOLD   = 4'd8;
`endif

  logic [3:0]    r_state, w_next;
  logic [CW-1:0] r_cnt, w_len;
  logic          w_done, w_long;
  logic          r_rs, r_en;
  logic [7:0]    r_data;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time
  assign w_long = !r_rs && (r_data == 8'h01 || r_data == 8'h02 || r_data == 8'h03);

  always_comb begin
    w_len = CW'(1);
    case (r_state)
      S_POWERUP: w_len = CW'(C_PWR);
      S_SETUP:   w_len = CW'(C_SET);
      S_PULSE:   w_len = CW'(C_PUL);
      S_HOLD:    w_len = CW'(C_HLD);
      S_EXEC:    w_len = w_long ? CW'(C_LONG) : CW'(C_EXE);
`ifdef LCD_BUSY_POLL_EN
      S_PSETUP:  w_len = CW'(C_SET);
      S_PPULSE:  w_len = CW'(C_PUL);
      S_PHOLD:   w_len = CW'(C_HLD);
`endif
      default:   w_len = CW'(1);
    endcase
  end

  assign w_done = (r_cnt == w_len - CW'(1));

`ifdef LCD_BUSY_POLL_EN
  logic          r_rw, r_flag, w_poll, w_poll_next, w_tmo;
  logic [CW-1:0] r_pcnt;
  assign w_poll      = (r_state == S_PSETUP) || (r_state == S_PPULSE) || (r_state == S_PHOLD);
  assign w_poll_next = (w_next == S_PSETUP) || (w_next == S_PPULSE) || (w_next == S_PHOLD);
  assign w_tmo       = w_poll && (r_pcnt == CW'(C_LONG - 1));
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_POWERUP;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_POWERUP: if (w_done) w_next = S_IDLE;
      S_IDLE:    if (cmd_valid) w_next = S_SETUP;
      S_SETUP:   if (w_done) w_next = S_PULSE;
      S_PULSE:   if (w_done) w_next = S_HOLD;
`ifdef LCD_BUSY_POLL_EN
      S_HOLD:    if (w_done) w_next = S_PSETUP;
`else
      S_HOLD:    if (w_done) w_next = S_EXEC;
`endif
      S_EXEC:    if (w_done) w_next = S_IDLE;
`ifdef LCD_BUSY_POLL_EN
      S_PSETUP:  if (w_tmo) w_next = S_IDLE; else if (w_done) w_next = S_PPULSE;
      S_PPULSE:  if (w_tmo) w_next = S_IDLE; else if (w_done) w_next = S_PHOLD;
      S_PHOLD:   if (w_tmo) w_next = S_IDLE; else if (w_done) w_next = r_flag ? S_PSETUP : S_IDLE;
`endif
      default:   w_next = S_POWERUP;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
  end

  // Up-counter restarts from zero on every state entry
  always_ff @(posedge clk) begin
    if (!reset)                                    r_cnt <= '0;
    else if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
    else                                           r_cnt <= r_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rs   <= 1'b0;
      r_data <= 8'h00;
      r_en   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      r_rw   <= 1'b0;
      r_flag <= 1'b0;
      r_pcnt <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_rs   <= cmd_rs;
        r_data <= cmd_data;
      end
`ifdef LCD_BUSY_POLL_EN
      r_en   <= (w_next == S_PULSE) || (w_next == S_PPULSE);
      r_rw   <= w_poll_next;
      r_pcnt <= w_poll ? r_pcnt + CW'(1) : '0;
      if (r_state == S_PPULSE && w_done) r_flag <= lcd_data_in[7];
`else
      r_en   <= (w_next == S_PULSE);
`endif
    end
  end

  assign lcd_en   = r_en;
  assign lcd_data = r_data;
`ifdef LCD_BUSY_POLL_EN
  assign lcd_rw   = r_rw;
  assign lcd_rs   = r_rs & ~r_rw;
`else
  assign lcd_rw   = 1'b0;
  assign lcd_rs   = r_rs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd1602_bus_driver.sv
`default_nettype none
// Bench for lcd1602_bus_driver: vector table, scoreboard on EN rising edges,
// plus hand-written power-up, streaming and mid-pulse reset sequences.
module tb_lcd1602_bus_driver;
  localparam int TP = 20, TS = 2, TPU = 5, TH = 2, TE = 10, TL = 40;

  logic       clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, lcd_rs, lcd_rw, lcd_en, busy;
  logic [7:0] lcd_data;

`ifdef LCD_BUSY_POLL_EN
  int         polls_done = 0, busy_n = 0, rd_rises = 0;
  logic [7:0] lcd_data_in;
  assign lcd_data_in = {(polls_done < busy_n), 7'd0};
`endif

  lcd1602_bus_driver #(
    .T_POWERUP_CYC(TP), .T_SETUP_CYC(TS), .T_PULSE_CYC(TPU),
    .T_HOLD_CYC(TH), .T_EXEC_CYC(TE), .T_EXEC_LONG_CYC(TL)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data),
`ifdef LCD_BUSY_POLL_EN
    .lcd_data_in(lcd_data_in),
`endif
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Post-HOLD wait the bench expects for a given fixed-EXEC length
  function automatic int exp_tail(input int len);
`ifdef LCD_BUSY_POLL_EN
    int t;
    t = (busy_n + 1) * (TS + TPU + TH);
    return (t > TL) ? TL : t;
`else
    return len;
`endif
  endfunction

  logic [8:0] sb[$];
  always @(posedge clk)
    if (reset && cmd_valid && cmd_ready) sb.push_back({cmd_rs, cmd_data});

  logic prev_en = 1'b0;
  int   en_w = 0;
  bit   abort_ok = 1'b0;
  int   rises[$];
  always @(negedge clk) begin
    logic [8:0] e;
    if (lcd_en && !prev_en) begin
      if (!lcd_rw) begin
        rises.push_back(cyc);
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          check("sb_rs", int'(lcd_rs), int'(e[8]));
          check("sb_data", int'(lcd_data), int'(e[7:0]));
        end
      end
`ifdef LCD_BUSY_POLL_EN
      else rd_rises++;
`endif
    end
    if (lcd_en) en_w++;
    else if (prev_en) begin
      if (!abort_ok) check("en_width", en_w, TPU);
      en_w = 0;
`ifdef LCD_BUSY_POLL_EN
      if (lcd_rw) polls_done++;
`endif
    end
    prev_en = lcd_en;
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("ready_timeout", 0, 1);
  endtask

  task automatic send_one(input logic rs, input logic [7:0] d, input int tail);
    int t_acc, r0, n;
`ifdef LCD_BUSY_POLL_EN
    polls_done = 0; rd_rises = 0;
`endif
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
    wait_ready(n);
    t_acc = cyc + 1;
    r0 = rises.size();
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rs = ~rs; cmd_data = ~d;
    check("bus_rs", int'(lcd_rs), int'(rs));
    check("bus_data", int'(lcd_data), int'(d));
    check("ready_low", int'(cmd_ready), 0);
    wait_ready(n);
    check("ready_return", cyc - t_acc, TS + TPU + TH + exp_tail(tail));
    if (rises.size() > r0) check("en_rise_latency", rises[r0] - t_acc, TS);
    else check("en_rise_missing", 0, 1);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         tail;
  } vec_t;

  initial begin
    vec_t v[8];
    int   t0, n, r0;
    int   ta[4];
    bit   en_seen;
    logic [7:0] sd[4];
    v[0] = '{rs: 1'b1, data: 8'h41, tail: TE};
    v[1] = '{rs: 1'b0, data: 8'h01, tail: TL};
    v[2] = '{rs: 1'b0, data: 8'h38, tail: TE};
    v[3] = '{rs: 1'b0, data: 8'h00, tail: TE};
    v[4] = '{rs: 1'b0, data: 8'h02, tail: TL};
    v[5] = '{rs: 1'b0, data: 8'h03, tail: TL};
    v[6] = '{rs: 1'b0, data: 8'h04, tail: TE};
    v[7] = '{rs: 1'b1, data: 8'h01, tail: TE};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_en", int'(lcd_en), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_data", int'(lcd_data), 0);

    // Power-up hold-off with a byte already waiting
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h41; reset = 1'b1;
    t0 = cyc; en_seen = 1'b0; n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk); n++;
      if (lcd_en) en_seen = 1'b1;
    end
    check("powerup_holdoff", cyc - t0, TP);
    check("powerup_en_low", int'(en_seen), 0);

    for (int i = 0; i < 8; i++) send_one(v[i].rs, v[i].data, v[i].tail);

    // Streaming with cmd_valid held high
    sd[0] = 8'h38; sd[1] = 8'h0C; sd[2] = 8'h01; sd[3] = 8'h80;
    r0 = rises.size();
    cmd_valid = 1'b1; cmd_rs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_data = sd[i];
      wait_ready(n);
      if (i == 3) check("stream_ready_after_clear", cyc - ta[2], TS + TPU + TH + exp_tail(TL));
      ta[i] = cyc + 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("stream_gap01", ta[1] - ta[0], TS + TPU + TH + exp_tail(TE) + 1);
    check("stream_gap12", ta[2] - ta[1], TS + TPU + TH + exp_tail(TE) + 1);
    check("stream_gap23", ta[3] - ta[2], TS + TPU + TH + exp_tail(TL) + 1);
    wait_ready(n);
    if (rises.size() >= r0 + 3) begin
      check("stream_en_gap01", rises[r0 + 1] - rises[r0], TS + TPU + TH + exp_tail(TE) + 1);
      check("stream_en_gap12", rises[r0 + 2] - rises[r0 + 1], TS + TPU + TH + exp_tail(TE) + 1);
    end else check("stream_en_count", rises.size() - r0, 4);

    // Reset asserted in the middle of the EN pulse
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    wait_ready(n);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 50) begin @(negedge clk); n++; end
    check("abort_en_seen", int'(lcd_en), 1);
    @(negedge clk);
    abort_ok = 1'b1; reset = 1'b0;
    @(negedge clk);
    check("abort_en_low", int'(lcd_en), 0);
    check("abort_ready", int'(cmd_ready), 0);
    check("abort_busy", int'(busy), 1);
    check("abort_data", int'(lcd_data), 0);
    reset = 1'b1; t0 = cyc;
    wait_ready(n);
    check("abort_holdoff", cyc - t0, TP);
    abort_ok = 1'b0;
    check("abort_no_extra_en", int'(lcd_en), 0);
    send_one(1'b1, 8'h41, TE);

`ifdef LCD_BUSY_POLL_EN
    busy_n = 3;
    send_one(1'b0, 8'h38, TE);
    check("poll_read_pulses", rd_rises, 4);
    check("poll_rw_idle", int'(lcd_rw), 0);
    busy_n = 1000;
    send_one(1'b0, 8'h38, TE);
    check("poll_timeout_rw", int'(lcd_rw), 0);
    busy_n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 500000);
    $fatal(1);
  end

endmodule
`default_nettype wire
